axi_rd_burst_reader: RTL and testbench
======================================

Name: axi_rd_burst_reader

Overview:
- Flat-signal AXI4 read master sitting directly upstream of the flat-to-AXI_BUS master bind stage.
- Drives its `mst_out_ar_*` / `mst_out_r_ready` outputs and consumes its `mst_in_ar_ready` / `mst_in_r_*` outputs.
- Accepts a (start address, beat count) command and splits it into INCR bursts that never cross a 4 KiB boundary, keeping up to MAX_OUTSTANDING bursts in flight.
- Streams read beats out under backpressure; reports completion and error.

Parameters:
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width; power of two, 8..1024.
- AXI_ID_WIDTH, 4, ID width.
- RD_ID, 0, constant ARID used for every burst.
- MAX_BURST_LEN, 16, max beats per burst (1..256).
- MAX_OUTSTANDING, 4, max AR bursts without final R beat (>=1).
- BEATS_WIDTH, 16, width of command beat count.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_addr_i  in  AXI_ADDR_WIDTH  start byte address; low log2(AXI_DATA_WIDTH/8) bits must be 0
- cmd_beats_i  in  BEATS_WIDTH  total beats to read
- mst_out_ar_id  out  AXI_ID_WIDTH  ARID (=RD_ID)
- mst_out_ar_addr  out  AXI_ADDR_WIDTH  ARADDR
- mst_out_ar_len  out  8  ARLEN
- mst_out_ar_size  out  3  ARSIZE = log2(AXI_DATA_WIDTH/8)
- mst_out_ar_burst  out  2  ARBURST = INCR (2'b01)
- mst_out_ar_valid  out  1  ARVALID
- mst_in_ar_ready  in  1  ARREADY
- mst_in_r_id  in  AXI_ID_WIDTH  RID
- mst_in_r_data  in  AXI_DATA_WIDTH  RDATA
- mst_in_r_resp  in  2  RRESP
- mst_in_r_last  in  1  RLAST
- mst_in_r_valid  in  1  RVALID
- mst_out_r_ready  out  1  RREADY
- data_o  out  AXI_DATA_WIDTH  read beat
- data_valid_o  out  1  beat valid
- data_ready_i  in  1  downstream ready
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag

The remaining AR fields (lock, cache, prot, qos, region, user) are not ports of this block. The parent ties them to 0 at the bind instance.

Behaviour:
- Reset (async, rst_i=1): all outputs 0 except `mst_out_ar_size` and `mst_out_ar_burst` (constant). FSM→IDLE; all counters 0.
- Reset asserted mid-operation: in-flight AXI transactions are abandoned. The parent must reset the slave side in the same reset domain.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `cmd_ready_o`=1.
  - On accept: latch addr, rem_ar=beats, rem_r=beats; clear `err_o`.
  - Next state is ISSUE if beats>0, else DONE.
- ISSUE:
  - `mst_out_ar_valid`=1 while outstanding<MAX_OUTSTANDING.
  - Burst length: n = min(rem_ar, MAX_BURST_LEN, (4096-addr[11:0])>>log2(bytes)); ar_len=n-1.
  - ar_addr/ar_len held stable while valid && !ready.
  - On AR handshake: addr+=n*bytes, rem_ar-=n, outstanding+=1. If rem_ar becomes 0 → DRAIN.
- DRAIN: wait until rem_r==0 → DONE.
- DONE: `done_o`=1 for exactly one cycle → IDLE. `err_o` is held until the next command accept.
- R path:
  - data_o=r_data, data_valid_o=r_valid, mst_out_r_ready=data_ready_i.
  - Pure combinational pass-through; zero latency, no buffering.
  - Each R handshake: rem_r-=1; if r_resp[1]==1 (SLVERR/DECERR) set `err_o`.
  - R handshake with r_last: outstanding-=1.
  - AR handshake and last-R handshake in the same cycle: outstanding unchanged.
- R-beat gating: R beats are only expected when outstanding>0. Beats arriving in IDLE are still passed through, but they do not change counters.
- Address math: wrap-around at 2^AXI_ADDR_WIDTH is not guarded. The caller guarantees the range fits.
- ISSUE with outstanding==MAX_OUTSTANDING: ar_valid=0 until a last beat retires.

Optional Feature:
Macro: AXI_RD_BURST_CHECK_EN.
- Defined: every R handshake checks r_id==RD_ID, and checks r_last==1 exactly on the final beat of each burst. A per-burst beat counter is tracked through a MAX_OUTSTANDING-deep FIFO of burst lengths. Any mismatch sets `err_o`; counting proceeds as normal.
- Undefined: no ID/last checking and no length FIFO; `err_o` reflects RRESP only.

Test Plan:
1. addr=0x1000, beats=16, MAX_BURST_LEN=16, 64-bit data, slave always ready → one AR (addr 0x1000, len 15); 16 beats on data_o; done_o pulses once; err_o=0.
2. addr=0x0FF0, beats=8, 64-bit → AR0 addr 0x0FF0 len 1; AR1 addr 0x1000 len 5 (4 KiB split); 8 beats total; one done_o.
3. beats=80, MAX_BURST_LEN=16, MAX_OUTSTANDING=4, slave withholds R → exactly 4 ARs issued, then ar_valid=0. Releasing one burst's RLAST allows the 5th AR.
4. beats=0 → no AR; done_o asserted exactly 2 cycles after cmd accept; cmd_ready_o=1 on the following cycle.
5. Beat 3 of 4 returns RRESP=2'b10 and data_ready_i toggles every cycle → all 4 beats delivered without loss or duplication; err_o=1 after beat 3, held through done_o, cleared on next cmd accept.
6. rst_i pulsed mid-ISSUE with 2 bursts outstanding → outputs zero asynchronously; after release, a new cmd (addr=0x2000, beats=4) completes normally. With AXI_RD_BURST_CHECK_EN defined, a wrong RID=5 on any beat sets err_o.

Source files
------------

// File: rtl/axi_rd_burst_reader.sv
// AXI4 read master: splits (addr, beats) commands into 4 KiB-safe INCR bursts, streams R beats through.
// Optional AXI_RD_BURST_CHECK_EN adds RID and RLAST-position checking into err_o.
module axi_rd_burst_reader #(
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int RD_ID           = 0,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BEATS_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BEATS_WIDTH-1:0]    cmd_beats_i,
  output logic [AXI_ID_WIDTH-1:0]   mst_out_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0] mst_out_ar_addr,
  output logic [7:0]                mst_out_ar_len,
  output logic [2:0]                mst_out_ar_size,
  output logic [1:0]                mst_out_ar_burst,
  output logic                      mst_out_ar_valid,
  input  logic                      mst_in_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]   mst_in_r_id,
  input  logic [AXI_DATA_WIDTH-1:0] mst_in_r_data,
  input  logic [1:0]                mst_in_r_resp,
  input  logic                      mst_in_r_last,
  input  logic                      mst_in_r_valid,
  output logic                      mst_out_r_ready,
  output logic [AXI_DATA_WIDTH-1:0] data_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic                      done_o,
  output logic                      err_o
);
  localparam int SIZE = $clog2(AXI_DATA_WIDTH/8);
  localparam int OW   = $clog2(MAX_OUTSTANDING+1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;

  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [BEATS_WIDTH-1:0]    rem_ar, rem_r;
  logic [8:0]                n_q;
  logic [OW-1:0]             outstanding;
  logic [31:0]               page_beats, n_c;
  logic                      ar_hs, r_hs, r_trk, r_retire, r_bad;
  logic                      unused_bits;

  assign data_o           = mst_in_r_data;
  assign data_valid_o     = mst_in_r_valid;
  assign mst_out_r_ready  = data_ready_i;
  assign mst_out_ar_size  = 3'(SIZE);
  assign mst_out_ar_burst = 2'b01;
  assign unused_bits      = ^{mst_in_r_id, mst_in_r_resp[0]};

  assign ar_hs    = mst_out_ar_valid & mst_in_ar_ready;
  assign r_hs     = mst_in_r_valid & data_ready_i;
  // Beats only count toward a command while a burst is actually in flight.
  assign r_trk    = r_hs && (outstanding != '0);
  assign r_retire = r_trk & mst_in_r_last;

  always_comb begin
    page_beats = (32'd4096 - {20'd0, addr_q[11:0]}) >> SIZE;
    n_c = 32'(rem_ar);
    if (n_c > 32'(MAX_BURST_LEN)) n_c = 32'(MAX_BURST_LEN);
    if (n_c > page_beats)         n_c = page_beats;
  end

`ifdef AXI_RD_BURST_CHECK_EN
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  logic [8:0]    len_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [8:0]    bcnt;
  logic          exp_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING-1)) ? '0 : p + PW'(1);
  endfunction

  assign exp_last = ((bcnt + 9'd1) == len_fifo[rd_ptr]);
  assign r_bad    = mst_in_r_resp[1] | (mst_in_r_id != AXI_ID_WIDTH'(RD_ID)) |
                    (mst_in_r_last != exp_last);

  always_ff @(posedge clk_i) if (ar_hs) len_fifo[wr_ptr] <= n_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bcnt   <= '0;
    end else begin
      if (ar_hs) wr_ptr <= ptr_inc(wr_ptr);
      if (r_trk) begin
        if (exp_last) begin
          bcnt   <= '0;
          rd_ptr <= ptr_inc(rd_ptr);
        end else bcnt <= bcnt + 9'd1;
      end
    end
  end
`else
  assign r_bad = mst_in_r_resp[1];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      cmd_ready_o      <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      addr_q           <= '0;
      rem_ar           <= '0;
      rem_r            <= '0;
      n_q              <= '0;
      outstanding      <= '0;
      mst_out_ar_valid <= 1'b0;
      mst_out_ar_addr  <= '0;
      mst_out_ar_len   <= '0;
      mst_out_ar_id    <= '0;
    end else begin
      done_o <= 1'b0;
      if (r_trk) begin
        rem_r <= rem_r - BEATS_WIDTH'(1);
        if (r_bad) err_o <= 1'b1;
      end
      if (ar_hs && !r_retire)      outstanding <= outstanding + OW'(1);
      else if (!ar_hs && r_retire) outstanding <= outstanding - OW'(1);

      case (state)
        IDLE: begin
          if (!cmd_ready_o) cmd_ready_o <= 1'b1;
          else if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            addr_q      <= cmd_addr_i;
            rem_ar      <= cmd_beats_i;
            rem_r       <= cmd_beats_i;
            err_o       <= 1'b0;
            state       <= (cmd_beats_i != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          // Burst fields are captured when valid rises, so they stay stable under stall.
          if (mst_out_ar_valid) begin
            if (mst_in_ar_ready) begin
              mst_out_ar_valid <= 1'b0;
              addr_q <= addr_q + (AXI_ADDR_WIDTH'(n_q) << SIZE);
              rem_ar <= rem_ar - BEATS_WIDTH'(n_q);
              if (rem_ar == BEATS_WIDTH'(n_q)) state <= DRAIN;
            end
          end else if (outstanding < OW'(MAX_OUTSTANDING)) begin
            mst_out_ar_valid <= 1'b1;
            mst_out_ar_addr  <= addr_q;
            mst_out_ar_len   <= 8'(n_c - 32'd1);
            mst_out_ar_id    <= AXI_ID_WIDTH'(RD_ID);
            n_q              <= 9'(n_c);
          end
        end
        DRAIN: if (rem_r == '0) state <= DONE;
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_burst_reader.sv
// Scoreboard bench for axi_rd_burst_reader: burst/beat reference model, reactive AXI slave, monitor.
module tb_axi_rd_burst_reader;
  localparam int AW = 64, DW = 64, IW = 4, BW = 16;

  logic          clk_i = 1'b0, rst_i;
  logic          cmd_valid_i, cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic [BW-1:0] cmd_beats_i;
  logic [IW-1:0] mst_out_ar_id;
  logic [AW-1:0] mst_out_ar_addr;
  logic [7:0]    mst_out_ar_len;
  logic [2:0]    mst_out_ar_size;
  logic [1:0]    mst_out_ar_burst;
  logic          mst_out_ar_valid, mst_in_ar_ready;
  logic [IW-1:0] mst_in_r_id;
  logic [DW-1:0] mst_in_r_data;
  logic [1:0]    mst_in_r_resp;
  logic          mst_in_r_last, mst_in_r_valid, mst_out_r_ready;
  logic [DW-1:0] data_o;
  logic          data_valid_o, data_ready_i, done_o, err_o;

  always #5 clk_i = ~clk_i;

  axi_rd_burst_reader dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_beats_i(cmd_beats_i),
    .mst_out_ar_id(mst_out_ar_id), .mst_out_ar_addr(mst_out_ar_addr),
    .mst_out_ar_len(mst_out_ar_len), .mst_out_ar_size(mst_out_ar_size),
    .mst_out_ar_burst(mst_out_ar_burst), .mst_out_ar_valid(mst_out_ar_valid),
    .mst_in_ar_ready(mst_in_ar_ready),
    .mst_in_r_id(mst_in_r_id), .mst_in_r_data(mst_in_r_data),
    .mst_in_r_resp(mst_in_r_resp), .mst_in_r_last(mst_in_r_last),
    .mst_in_r_valid(mst_in_r_valid), .mst_out_r_ready(mst_out_r_ready),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .done_o(done_o), .err_o(err_o)
  );

  int total = 0, bad = 0;
  logic [63:0] exp_ar_addr[$];
  int          exp_ar_len[$];
  logic [63:0] exp_data[$];
  logic [63:0] sq_addr[$];
  int          sq_len[$];
  int ar_cnt = 0, done_cnt = 0, dhs_cnt = 0;
  int r_credit = 1000000, beat_no = 0, inj_beat = -1, bidx = 0, dr_mode = 0;
  bit ar_rand = 0, r_rand = 0;
  logic [IW-1:0] rid_val = '0;

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic tick;
    @(negedge clk_i);
    #2;
  endtask

  // Reference: bursts of min(remaining, 16, beats left in 4 KiB page); data is pat(address).
  task automatic model(input logic [63:0] a, input int beats);
    int r, n, pg;
    r = beats;
    while (r > 0) begin
      pg = (4096 - int'(a % 64'd4096)) / 8;
      n = r;
      if (n > 16) n = 16;
      if (n > pg) n = pg;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(n - 1);
      for (int k = 0; k < n; k++) exp_data.push_back(pat(a + 64'(8 * k)));
      a += 64'(8 * n);
      r -= n;
    end
  endtask

  // Monitor: everything sampled mid-cycle reflects the handshake at the next rising edge.
  always @(negedge clk_i) if (!rst_i) begin
    if (mst_out_ar_valid && mst_in_ar_ready) begin
      ar_cnt++;
      sq_addr.push_back(mst_out_ar_addr);
      sq_len.push_back(int'(mst_out_ar_len));
      if (exp_ar_addr.size() == 0) fail("ar_unexpected");
      else begin
        chk("ar_addr", mst_out_ar_addr, exp_ar_addr.pop_front());
        chk("ar_len", 64'(mst_out_ar_len), 64'(exp_ar_len.pop_front()));
      end
      chk("ar_id", 64'(mst_out_ar_id), 64'(0));
    end
    if (data_valid_o && data_ready_i) begin
      dhs_cnt++;
      if (exp_data.size() == 0) fail("data_unexpected");
      else chk("data", data_o, exp_data.pop_front());
    end
    if (done_o) done_cnt++;
  end

  // Slave + sink driver, updated just after each rising edge.
  initial begin
    bit rh;
    mst_in_ar_ready = 0; mst_in_r_valid = 0; mst_in_r_last = 0;
    mst_in_r_data = '0; mst_in_r_resp = '0; mst_in_r_id = '0; data_ready_i = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_i) begin
        sq_addr.delete(); sq_len.delete(); bidx = 0;
        mst_in_r_valid = 0; mst_in_r_last = 0; mst_in_ar_ready = 0; data_ready_i = 0;
      end else begin
        rh = mst_in_r_valid && data_ready_i;
        if (rh) begin
          mst_in_r_valid = 0;
          if (bidx == sq_len[0]) begin
            void'(sq_addr.pop_front()); void'(sq_len.pop_front()); bidx = 0;
          end else bidx++;
        end
        if (!mst_in_r_valid && sq_addr.size() > 0 && r_credit > 0 &&
            (!r_rand || $urandom_range(3) != 0)) begin
          mst_in_r_valid = 1;
          mst_in_r_data  = pat(sq_addr[0] + 64'(8 * bidx));
          mst_in_r_last  = (bidx == sq_len[0]);
          mst_in_r_resp  = (beat_no == inj_beat) ? 2'b10 : 2'b00;
          mst_in_r_id    = rid_val;
          beat_no++;
          r_credit--;
        end
        mst_in_ar_ready = ar_rand ? 1'($urandom_range(1)) : 1'b1;
        case (dr_mode)
          0:       data_ready_i = 1'b1;
          1:       data_ready_i = ~data_ready_i;
          default: data_ready_i = 1'($urandom_range(1));
        endcase
      end
    end
  end

  task automatic issue_cmd(input logic [63:0] a, input int beats);
    bit acc;
    acc = 0;
    beat_no = 0;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1; cmd_addr_i = a; cmd_beats_i = BW'(beats);
    for (int i = 0; i < 100; i++) begin
      tick;
      acc = cmd_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) break;
    end
    cmd_valid_i = 0;
    if (!acc) fail("cmd_accept_timeout");
  endtask

  task automatic wait_done(input int prev, input int bound);
    int i;
    i = 0;
    while (done_cnt == prev && i < bound) begin tick; i++; end
    if (done_cnt == prev) fail("done_timeout");
  endtask

  task automatic run_cmd(input logic [63:0] a, input int beats, input bit exp_err);
    int d0;
    d0 = done_cnt;
    model(a, beats);
    issue_cmd(a, beats);
    tick;
    chk("err_clear_on_accept", err_o, 0);
    wait_done(d0, 3000);
    chk("err_at_done", err_o, exp_err);
    tick; tick;
    chk("done_once", 64'(done_cnt - d0), 1);
    chk("ar_left", 64'(exp_ar_addr.size()), 0);
    chk("data_left", 64'(exp_data.size()), 0);
  endtask

  initial begin
    #200000;
    fail("global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int a0, d0, n;
    logic [63:0] ra;
    rst_i = 1; cmd_valid_i = 0; cmd_addr_i = '0; cmd_beats_i = '0;
    repeat (3) @(posedge clk_i);
    tick;
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_ar_valid", mst_out_ar_valid, 0);
    chk("rst_ar_addr", mst_out_ar_addr, 0);
    chk("rst_ar_len", 64'(mst_out_ar_len), 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ar_size", 64'(mst_out_ar_size), 3);
    chk("rst_ar_burst", 64'(mst_out_ar_burst), 1);
    @(posedge clk_i);
    #1;
    rst_i = 0;
    tick; tick;
    chk("idle_cmd_ready", cmd_ready_o, 1);

    // single aligned burst, then a 4 KiB split
    run_cmd(64'h1000, 16, 0);
    run_cmd(64'h0FF0, 8, 0);

    // outstanding cap with R withheld
    r_credit = 0;
    a0 = ar_cnt; d0 = done_cnt;
    model(64'h4000, 80);
    issue_cmd(64'h4000, 80);
    for (int i = 0; i < 200 && ar_cnt - a0 < 4; i++) tick;
    repeat (20) tick;
    chk("ar_cnt_capped", 64'(ar_cnt - a0), 4);
    chk("ar_valid_capped", mst_out_ar_valid, 0);
    r_credit = 16;
    for (int i = 0; i < 200 && ar_cnt - a0 < 5; i++) tick;
    chk("ar_fifth_after_retire", 64'(ar_cnt - a0), 5);
    r_credit = 1000000;
    wait_done(d0, 3000);
    chk("cap_err", err_o, 0);
    chk("cap_data_left", 64'(exp_data.size()), 0);

    // zero-beat command timing
    tick;
    d0 = done_cnt; a0 = ar_cnt;
    issue_cmd(64'h3000, 0);
    tick; chk("zero_done_c1", done_o, 0);
    tick; chk("zero_done_c2", done_o, 1);
    tick; chk("zero_done_c3", done_o, 0);
    chk("zero_ready_c3", cmd_ready_o, 1);
    chk("zero_no_ar", 64'(ar_cnt - a0), 0);
    chk("zero_done_cnt", 64'(done_cnt - d0), 1);

    // SLVERR on beat 3 of 4 with toggling downstream ready
    inj_beat = 2; dr_mode = 1;
    d0 = done_cnt; a0 = dhs_cnt;
    model(64'h5000, 4);
    issue_cmd(64'h5000, 4);
    for (int i = 0; i < 200 && dhs_cnt - a0 < 3; i++) tick;
    chk("err_before_bad_beat", err_o, 0);
    tick;
    chk("err_after_bad_beat", err_o, 1);
    wait_done(d0, 3000);
    chk("err_held_at_done", err_o, 1);
    tick; tick;
    chk("err_held_after_done", err_o, 1);
    chk("err_beats_delivered", 64'(dhs_cnt - a0), 4);
    chk("err_data_left", 64'(exp_data.size()), 0);
    inj_beat = -1; dr_mode = 0;
    run_cmd(64'h5000, 4, 0);

    // reset mid-ISSUE with two bursts outstanding
    r_credit = 0;
    a0 = ar_cnt;
    model(64'h8000, 80);
    issue_cmd(64'h8000, 80);
    for (int i = 0; i < 200 && ar_cnt - a0 < 2; i++) tick;
    chk("mid_two_ar", 64'(ar_cnt - a0), 2);
    #1 rst_i = 1;
    #1;
    chk("mid_rst_ar_valid", mst_out_ar_valid, 0);
    chk("mid_rst_ar_addr", mst_out_ar_addr, 0);
    chk("mid_rst_ar_len", 64'(mst_out_ar_len), 0);
    chk("mid_rst_cmd_ready", cmd_ready_o, 0);
    chk("mid_rst_done", done_o, 0);
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
    repeat (2) @(posedge clk_i);
    #1;
    r_credit = 1000000;
    rst_i = 0;
    tick; tick;
    run_cmd(64'h2000, 4, 0);

`ifdef AXI_RD_BURST_CHECK_EN
    rid_val = 5;
    run_cmd(64'h6000, 4, 1);
    rid_val = '0;
`endif

    // randomized commands with random handshakes
    ar_rand = 1; r_rand = 1; dr_mode = 2;
    for (int t = 0; t < 10; t++) begin
      ra = 64'($urandom_range(0, 32'h000F_FFFF)) & ~64'h7;
      n  = $urandom_range(1, 70);
      inj_beat = ($urandom_range(3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_cmd(ra, n, inj_beat >= 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
